// File: rtl/mod_clk_monitor.sv
// Receive-side checker for the MOD/MODN/MODL modulation clocks: period, high time, phase, lock and error flags.
// Optional MODCLK_PHASE_CHECK_EN adds PHASE_SEL / PHASE_ERR phase comparison while locked.
module mod_clk_monitor #(
    parameter int CNT_W      = 8,
    parameter int EXP_PERIOD = 32,
    parameter int LOCK_COUNT = 4
) (
    input  logic             CLK_IN,
    input  logic             RESET,
    input  logic             MOD_IN,
    input  logic             MODN_IN,
    input  logic             MODL_IN,
    input  logic             CLR_ERR,
`ifdef MODCLK_PHASE_CHECK_EN
    input  logic [4:0]       PHASE_SEL,
    output logic             PHASE_ERR,
`endif
    output logic [CNT_W-1:0] PERIOD,
    output logic [CNT_W-1:0] HIGH_TIME,
    output logic [4:0]       PHASE_MEAS,
    output logic             MEAS_VALID,
    output logic             LOCKED,
    output logic             OVERLAP_ERR,
    output logic             PERIOD_ERR
);

    // state   | meaning
    // SEARCH  | waiting for first MOD rise, nothing published
    // MEASURE | publishing periods, counting consecutive good ones
    // LOCK    | LOCK_COUNT good periods seen, LOCKED asserted

    typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_LOCK} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_PRE_SAT = CNT_MAX - 1'b1;
    localparam logic [CNT_W-1:0] CNT_EXP     = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [3:0]       GOOD_LOCK   = 4'(LOCK_COUNT);

    logic r_mod, p_mod, r_modn, r_modl, p_modl;
    logic [CNT_W-1:0] cnt, hcnt;
    logic [4:0] ph;
    logic [3:0] good;
    state_t state;

    logic mod_rise, mod_fall, modl_rise, period_ok, cnt_sat_next, publish, perr_set;

    always_ff @(posedge CLK_IN or posedge RESET) begin
        if (RESET) begin
            r_mod  <= 1'b0;
            p_mod  <= 1'b0;
            r_modn <= 1'b0;
            r_modl <= 1'b0;
            p_modl <= 1'b0;
        end else begin
            r_mod  <= MOD_IN;
            p_mod  <= r_mod;
            r_modn <= MODN_IN;
            r_modl <= MODL_IN;
            p_modl <= r_modl;
        end
    end

    assign mod_rise     = r_mod & ~p_mod;
    assign mod_fall     = ~r_mod & p_mod;
    assign modl_rise    = r_modl & ~p_modl;
    assign period_ok    = (cnt == CNT_EXP);
    // a stuck clock is flagged once, on the cycle the period counter hits its ceiling
    assign cnt_sat_next = ~mod_rise & (cnt == CNT_PRE_SAT);
    assign publish      = mod_rise & (state != ST_SEARCH);
    assign perr_set     = cnt_sat_next | (publish & ~period_ok);

    always_ff @(posedge CLK_IN or posedge RESET) begin
        if (RESET) begin
            cnt       <= '0;
            hcnt      <= '0;
            ph        <= '0;
            HIGH_TIME <= '0;
        end else begin
            if (mod_rise)
                cnt <= CNT_ONE;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;

            if (mod_rise)
                hcnt <= CNT_ONE;
            else if (r_mod && hcnt != CNT_MAX)
                hcnt <= hcnt + 1'b1;

            if (mod_fall)
                HIGH_TIME <= hcnt;

            if (modl_rise)
                ph <= cnt[4:0];
        end
    end

    always_ff @(posedge CLK_IN or posedge RESET) begin
        if (RESET) begin
            state       <= ST_SEARCH;
            good        <= '0;
            PERIOD      <= '0;
            PHASE_MEAS  <= '0;
            MEAS_VALID  <= 1'b0;
            LOCKED      <= 1'b0;
            OVERLAP_ERR <= 1'b0;
            PERIOD_ERR  <= 1'b0;
        end else begin
            MEAS_VALID  <= publish;
            PERIOD_ERR  <= perr_set | (PERIOD_ERR & ~CLR_ERR);
            OVERLAP_ERR <= (r_mod & r_modn) | (OVERLAP_ERR & ~CLR_ERR);
            if (publish) begin
                PERIOD     <= cnt;
                PHASE_MEAS <= ph;
            end

            if (cnt_sat_next) begin
                state  <= ST_SEARCH;
                good   <= '0;
                LOCKED <= 1'b0;
            end else if (mod_rise) begin
                case (state)
                    ST_SEARCH: begin
                        state <= ST_MEASURE;
                        good  <= '0;
                    end
                    ST_MEASURE: begin
                        if (!period_ok) begin
                            good <= '0;
                        end else if (good + 4'd1 == GOOD_LOCK) begin
                            good   <= GOOD_LOCK;
                            state  <= ST_LOCK;
                            LOCKED <= 1'b1;
                        end else begin
                            good <= good + 4'd1;
                        end
                    end
                    ST_LOCK: begin
                        if (!period_ok) begin
                            state  <= ST_MEASURE;
                            good   <= '0;
                            LOCKED <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= ST_SEARCH;
                        good   <= '0;
                        LOCKED <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef MODCLK_PHASE_CHECK_EN
    logic phase_set;
    assign phase_set = mod_rise & (state == ST_LOCK) & (ph != PHASE_SEL);

    always_ff @(posedge CLK_IN or posedge RESET) begin
        if (RESET)
            PHASE_ERR <= 1'b0;
        else
            PHASE_ERR <= phase_set | (PHASE_ERR & ~CLR_ERR);
    end
`endif

endmodule
